// File: rtl/ysyx_23060077_ifu_pred_queue_pkg.sv
// Shared widths, predecode bit positions, opcodes and queue FSM encodings
// for the IFU prediction queue.
package ysyx_23060077_ifu_pred_queue_pkg;

    localparam int INST_WIDTH    = 32;
    localparam int PRE_OPT_WIDTH = 6;

    // Predecode vector is {JAL, JALR, BRANCH, SYS, ECALL, MRET}, MSB first
    localparam int PRE_JAL    = 5;
    localparam int PRE_JALR   = 4;
    localparam int PRE_BRANCH = 3;
    localparam int PRE_SYS    = 2;
    localparam int PRE_ECALL  = 1;
    localparam int PRE_MRET   = 0;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        PQ_RUN   = 2'd0,
        PQ_REDIR = 2'd1,
        PQ_HOLD  = 2'd2
    } pq_state_e;

endpackage

// File: rtl/ysyx_23060077_static_bpu.sv
// Static predictor: JAL always taken, BRANCH taken only when backward
// (sign bit of the offset set); everything else falls through to pc+4.
module ysyx_23060077_static_bpu
    import ysyx_23060077_ifu_pred_queue_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0]      pc_i,
    input  logic [INST_WIDTH-1:0]    inst_i,
    input  logic [PRE_OPT_WIDTH-1:0] pre_i,
    output logic                     pred_taken_o,
    output logic [PC_WIDTH-1:0]      pred_pc_o
);
    logic [PC_WIDTH-1:0] j_imm;
    logic [PC_WIDTH-1:0] b_imm;
    logic                is_jal;
    logic                is_br;
    logic                unused_ok;

    assign j_imm = {{(PC_WIDTH-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign b_imm = {{(PC_WIDTH-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

    assign is_jal = pre_i[PRE_JAL];
    assign is_br  = pre_i[PRE_BRANCH];

    always_comb begin
        pred_taken_o = 1'b0;
        pred_pc_o    = pc_i + PC_WIDTH'(4);
        if (is_jal) begin
            pred_taken_o = 1'b1;
            pred_pc_o    = pc_i + j_imm;
        end else if (is_br && inst_i[31]) begin
            pred_taken_o = 1'b1;
            pred_pc_o    = pc_i + b_imm;
        end
    end

    assign unused_ok = ^{inst_i[6:0], pre_i[PRE_JALR], pre_i[PRE_SYS], pre_i[PRE_ECALL], pre_i[PRE_MRET]};

endmodule

// File: rtl/ysyx_23060077_ifu_pred_queue.sv
// Instruction queue between pre-decode and IDU: stores each entry with its
// static prediction, issues a one-cycle redirect and holds fetch on JALR/SYS.
module ysyx_23060077_ifu_pred_queue
    import ysyx_23060077_ifu_pred_queue_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_WIDTH-1:0]      in_pc,
    input  logic [INST_WIDTH-1:0]    in_inst,
    input  logic [PRE_OPT_WIDTH-1:0] in_predecode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [INST_WIDTH-1:0]    out_inst,
    output logic [PRE_OPT_WIDTH-1:0] out_predecode,
    output logic                     out_pred_taken,
    output logic [PC_WIDTH-1:0]      out_pred_pc,
    output logic                     redirect_valid,
    output logic [PC_WIDTH-1:0]      redirect_pc,
    input  logic                     flush
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int E_W   = 2*PC_WIDTH + INST_WIDTH + PRE_OPT_WIDTH + 1;

    logic [E_W-1:0]      ent_q [DEPTH];
    logic [E_W-1:0]      last_q;
    logic [E_W-1:0]      head;
    logic [E_W-1:0]      in_ent;
    logic [PTR_W-1:0]    wr_q, rd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PC_WIDTH-1:0] redir_pc_q;
    pq_state_e           state_q, state_d;

    logic                bp_taken;
    logic [PC_WIDTH-1:0] bp_pc;
    logic                enq, deq, hold_cls;

    ysyx_23060077_static_bpu #(.PC_WIDTH(PC_WIDTH)) u_bpu (
        .pc_i         (in_pc),
        .inst_i       (in_inst),
        .pre_i        (in_predecode),
        .pred_taken_o (bp_taken),
        .pred_pc_o    (bp_pc)
    );

    assign in_ready  = (state_q == PQ_RUN) & (cnt_q < CNT_W'(DEPTH)) & ~flush;
    assign out_valid = (cnt_q != '0);
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;
    assign hold_cls  = in_predecode[PRE_JALR] | in_predecode[PRE_SYS];

    assign in_ent = {in_pc, in_inst, in_predecode, bp_taken, bp_pc};
    // When empty, the last presented head stays visible rather than a stale slot
    assign head   = out_valid ? ent_q[rd_q] : last_q;
    assign {out_pc, out_inst, out_predecode, out_pred_taken, out_pred_pc} = head;

    assign redirect_valid = (state_q == PQ_REDIR) & ~flush;
    assign redirect_pc    = redir_pc_q;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = PQ_RUN;
        end else begin
            case (state_q)
                PQ_RUN: begin
                    if (enq && bp_taken)      state_d = PQ_REDIR;
                    else if (enq && hold_cls) state_d = PQ_HOLD;
                end
                PQ_REDIR: state_d = PQ_RUN;
                PQ_HOLD:  state_d = PQ_HOLD;
                default:  state_d = PQ_RUN;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            last_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            redir_pc_q <= '0;
            state_q    <= PQ_RUN;
        end else begin
            state_q <= state_d;
            if (out_valid) last_q <= ent_q[rd_q];
            if (enq) begin
                ent_q[wr_q] <= in_ent;
                if (bp_taken) redir_pc_q <= bp_pc;
            end
            if (flush) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (enq) wr_q <= wr_q + PTR_W'(1);
                if (deq) rd_q <= rd_q + PTR_W'(1);
                cnt_q <= cnt_q + CNT_W'(enq) - CNT_W'(deq);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_ifu_pred_queue.sv
// Directed bench for the IFU prediction queue with hand-computed expectations.
module tb_ysyx_23060077_ifu_pred_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_inst;
    logic [5:0]  in_predecode;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst;
    logic [5:0]  out_predecode;
    logic        out_pred_taken;
    logic [31:0] out_pred_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_JAL  = 6'b100000;
    localparam logic [5:0] P_BR   = 6'b001000;
    localparam logic [5:0] P_ECL  = 6'b000110;

    ysyx_23060077_ifu_pred_queue #(.DEPTH(2), .PC_WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .in_predecode   (in_predecode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_predecode  (out_predecode),
        .out_pred_taken (out_pred_taken),
        .out_pred_pc    (out_pred_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [5:0] pre);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_inst      = inst;
        in_predecode = pre;
    endtask

    task automatic idle_in();
        in_valid     = 1'b0;
        in_pc        = '0;
        in_inst      = '0;
        in_predecode = '0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        idle_in();
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_redir", redirect_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_redir_pc", redirect_pc, 0);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // addi, consumed the cycle after it appears
        drive(32'h8000_0000, 32'h0000_0013, P_NONE);
        out_ready = 1'b1;
        tick();
        idle_in();
        check("addi_valid", out_valid, 1);
        check("addi_pc", out_pc, 32'h8000_0000);
        check("addi_inst", out_inst, 32'h0000_0013);
        check("addi_taken", out_pred_taken, 0);
        check("addi_pred", out_pred_pc, 32'h8000_0004);
        check("addi_redir", redirect_valid, 0);
        tick();
        check("addi_drained", out_valid, 0);
        check("empty_hold_pc", out_pc, 32'h8000_0000);
        check("addi_redir2", redirect_valid, 0);

        // pc+4 wraps modulo 2^32
        drive(32'hFFFF_FFFC, 32'h0000_0013, P_NONE);
        tick();
        idle_in();
        check("wrap_pred", out_pred_pc, 32'h0000_0000);
        tick();

        // JAL: taken, one-cycle redirect
        out_ready = 1'b0;
        drive(32'h8000_0000, 32'h0080_006F, P_JAL);
        tick();
        idle_in();
        check("jal_taken", out_pred_taken, 1);
        check("jal_pred", out_pred_pc, 32'h8000_0008);
        check("jal_redir", redirect_valid, 1);
        check("jal_redir_pc", redirect_pc, 32'h8000_0008);
        check("jal_in_ready", in_ready, 0);
        tick();
        check("jal_redir_off", redirect_valid, 0);
        check("jal_run", in_ready, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("jal_drained", out_valid, 0);

        // backward beq: taken
        drive(32'h8000_0010, 32'hFE00_0EE3, P_BR);
        tick();
        idle_in();
        check("bwd_taken", out_pred_taken, 1);
        check("bwd_redir", redirect_valid, 1);
        check("bwd_redir_pc", redirect_pc, 32'h8000_000C);
        out_ready = 1'b1;
        tick();
        check("bwd_drained", out_valid, 0);

        // forward beq: not taken
        drive(32'h8000_0010, 32'h0000_0463, P_BR);
        out_ready = 1'b0;
        tick();
        idle_in();
        check("fwd_taken", out_pred_taken, 0);
        check("fwd_pred", out_pred_pc, 32'h8000_0014);
        check("fwd_redir", redirect_valid, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // fill to DEPTH, then drain in order
        drive(32'h0000_0100, 32'h0000_0013, P_NONE);
        check("fill0_ready", in_ready, 1);
        tick();
        drive(32'h0000_0104, 32'h0000_0013, P_NONE);
        check("fill1_ready", in_ready, 1);
        tick();
        idle_in();
        check("full_ready", in_ready, 0);
        check("full_head", out_pc, 32'h0000_0100);
        out_ready = 1'b1;
        tick();
        check("drain1_pc", out_pc, 32'h0000_0104);
        check("drain1_ready", in_ready, 1);
        // simultaneous enqueue and dequeue at count=1
        drive(32'h0000_0108, 32'h0000_0013, P_NONE);
        tick();
        idle_in();
        check("simul_valid", out_valid, 1);
        check("simul_pc", out_pc, 32'h0000_0108);
        tick();
        check("simul_drained", out_valid, 0);

        // ecall: hold until flush
        out_ready = 1'b0;
        drive(32'h0000_0200, 32'h0000_0073, P_ECL);
        tick();
        idle_in();
        check("ecall_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("hold_ready", in_ready, 0);
            tick();
        end
        check("hold_drained", out_valid, 0);
        flush = 1'b1;
        #1;
        check("flush_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        check("post_flush_ready", in_ready, 1);
        check("post_flush_valid", out_valid, 0);

        // flush during the redirect cycle
        out_ready = 1'b0;
        drive(32'h8000_0000, 32'h0080_006F, P_JAL);
        tick();
        idle_in();
        check("pre_flush_redir", redirect_valid, 1);
        flush = 1'b1;
        #1;
        check("flush_redir", redirect_valid, 0);
        check("flush_redir_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        check("flushed_valid", out_valid, 0);
        check("flushed_redir", redirect_valid, 0);
        check("flushed_ready", in_ready, 1);

        // async reset mid-HOLD with one entry queued
        drive(32'h0000_0300, 32'h0000_0073, P_ECL);
        tick();
        idle_in();
        check("hold_cnt1_valid", out_valid, 1);
        check("hold_cnt1_ready", in_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_pc", out_pc, 0);
        #2;
        reset = 1'b0;
        tick();
        check("async_rst_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
